// File: rtl/iob_eth_rx_pkg.sv
// Shared definitions for the Ethernet MII receiver: FSM state encoding,
// framing constants and a destination-MAC byte selector.
package iob_eth_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StData,
    StDone,
    StDrop
  } rx_state_e;

  localparam logic [3:0]  PreambleNibble = 4'h5;
  localparam logic [3:0]  SfdNibble      = 4'hD;
  localparam logic [7:0]  SfdByte        = 8'hD5;
  localparam logic [7:0]  BcastByte      = 8'hFF;
  localparam int unsigned HdrLen         = 14;
  localparam int unsigned MacBytes       = 6;

  // Byte idx (1..6) of a MAC address in wire order; idx 1 is mac[47:40].
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int unsigned idx);
    logic [47:0] sh;
    sh = mac >> (8 * (MacBytes - idx));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/iob_eth_rx_if.sv
// Receive-buffer write port bundle.
//   buf_addr  - byte write address
//   buf_wdata - byte to write
//   buf_we    - write strobe, one cycle per byte
// master: receiver side (drives); slave: buffer RAM side.
interface iob_eth_rx_if #(
  parameter int unsigned BufAddrW = 11
);
  logic [BufAddrW-1:0] buf_addr;
  logic [7:0]          buf_wdata;
  logic                buf_we;

  modport master (output buf_addr, output buf_wdata, output buf_we);
  modport slave  (input buf_addr, input buf_wdata, input buf_we);
endinterface

// File: rtl/iob_eth_rx.sv
// MII (4-bit) Ethernet frame receiver. Hunts for preamble + SFD, writes the
// SFD byte followed by the frame into an external byte buffer, filters on the
// destination MAC (own address or broadcast) and checks the length.
//   clk, rst_n        - RX_CLK domain, async active-low reset
//   rx_dv, rx_data    - MII receive data valid / nibble
//   mac_addr          - local MAC, [47:40] first on the wire
//   rx_nbytes         - expected payload byte count after the 14-byte header
//   rcv_ack           - releases a completed frame, clears rx_err
//   bus               - buffer write port (addr/wdata/we)
//   rx_ready, rx_err  - frame held in buffer / last frame dropped (sticky)
module iob_eth_rx
  import iob_eth_rx_pkg::*;
#(
  parameter int unsigned BUF_ADDR_W   = 11,
  parameter int unsigned PREAMBLE_MIN = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_dv,
  input  logic [3:0]            rx_data,
  input  logic [47:0]           mac_addr,
  input  logic [BUF_ADDR_W-1:0] rx_nbytes,
  input  logic                  rcv_ack,
  iob_eth_rx_if.master          bus,
  output logic                  rx_ready,
  output logic                  rx_err
);

  localparam logic [BUF_ADDR_W-1:0] AddrMax   = '1;
  localparam logic [BUF_ADDR_W-1:0] HdrTail   = BUF_ADDR_W'(HdrLen + 1);
  localparam logic [BUF_ADDR_W-1:0] DestFirst = BUF_ADDR_W'(1);
  localparam logic [BUF_ADDR_W-1:0] DestLast  = BUF_ADDR_W'(MacBytes);
  localparam logic [3:0]            PreMin    = 4'(PREAMBLE_MIN);

  rx_state_e             state_q, state_d;
  logic [3:0]            pre_cnt_q, pre_cnt_d;
  logic                  nib_q, nib_d;        // low nibble held, awaiting high
  logic [3:0]            lo_q, lo_d;
  logic                  mac_ok_q, mac_ok_d;  // dest prefix matches mac_addr
  logic                  bc_ok_q, bc_ok_d;    // dest prefix is all-ones
  logic                  dv_q;                // rx_dv last cycle
  logic [BUF_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;

  logic [7:0]            byte_in;
  logic [BUF_ADDR_W-1:0] written;
  logic                  in_dest;

  always_comb begin
    byte_in = {rx_data, lo_q};
    // A write still in flight has not advanced addr_q yet.
    written = addr_q + BUF_ADDR_W'(we_q);
    in_dest = (addr_q >= DestFirst) && (addr_q <= DestLast);
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    nib_d     = nib_q;
    lo_d      = lo_q;
    mac_ok_d  = mac_ok_q;
    bc_ok_d   = bc_ok_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    err_d     = err_q;

    if (we_q) addr_d = addr_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        // Only a fresh rx_dv rise starts a frame; a frame already in progress
        // (after reset or release from DONE) is ignored until the line idles.
        if (rx_dv && !dv_q) begin
          if (rx_data == PreambleNibble) begin
            state_d   = StPreamble;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!rx_dv) begin
          state_d = StDrop;
        end else if (rx_data == PreambleNibble) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (rx_data == SfdNibble && pre_cnt_q >= PreMin) begin
          state_d  = StData;
          addr_d   = '0;
          wdata_d  = SfdByte;
          we_d     = 1'b1;
          nib_d    = 1'b0;
          mac_ok_d = 1'b1;
          bc_ok_d  = 1'b1;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (!rx_dv) begin
          state_d = (nib_q || written != rx_nbytes + HdrTail) ? StDrop : StDone;
        end else if (addr_q == AddrMax) begin
          state_d = StDrop;
        end else if (!nib_q) begin
          lo_d  = rx_data;
          nib_d = 1'b1;
        end else begin
          nib_d = 1'b0;
          if (in_dest) begin
            mac_ok_d = mac_ok_q && (byte_in == mac_byte(mac_addr, 32'(addr_q)));
            bc_ok_d  = bc_ok_q && (byte_in == BcastByte);
          end
          // A failing destination byte is not written.
          if (in_dest && !mac_ok_d && !bc_ok_d) begin
            state_d = StDrop;
          end else begin
            wdata_d = byte_in;
            we_d    = 1'b1;
          end
        end
      end
      StDone: begin
        if (rcv_ack) begin
          state_d = StIdle;
          addr_d  = '0;
        end
      end
      StDrop: begin
        if (!rx_dv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StDrop && state_q != StDrop) begin
      err_d = 1'b1;
    end else if (state_d == StDone && state_q != StDone) begin
      err_d = 1'b0;
    end else if (rcv_ack) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pre_cnt_q <= '0;
      nib_q     <= 1'b0;
      lo_q      <= '0;
      mac_ok_q  <= 1'b0;
      bc_ok_q   <= 1'b0;
      dv_q      <= 1'b1;  // treat the line as busy until rx_dv is seen low
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      nib_q     <= nib_d;
      lo_q      <= lo_d;
      mac_ok_q  <= mac_ok_d;
      bc_ok_q   <= bc_ok_d;
      dv_q      <= rx_dv;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      err_q     <= err_d;
    end
  end

  assign bus.buf_addr  = addr_q;
  assign bus.buf_wdata = wdata_q;
  assign bus.buf_we    = we_q;
  assign rx_ready      = (state_q == StDone);
  assign rx_err        = err_q;

endmodule

// File: tb/tb_iob_eth_rx.sv
// Bench for iob_eth_rx: directed scenarios plus randomized frames checked
// against a frame-level model of acceptance and buffer contents.
module tb_iob_eth_rx;
  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst_n, rx_dv, rcv_ack;
  logic [3:0]    rx_data;
  logic [47:0]   mac_addr;
  logic [AW-1:0] rx_nbytes;
  logic          rx_ready, rx_err;

  iob_eth_rx_if #(.BufAddrW(AW)) bus ();

  iob_eth_rx #(.BUF_ADDR_W(AW), .PREAMBLE_MIN(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_dv     (rx_dv),
    .rx_data   (rx_data),
    .mac_addr  (mac_addr),
    .rx_nbytes (rx_nbytes),
    .rcv_ack   (rcv_ack),
    .bus       (bus),
    .rx_ready  (rx_ready),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Buffer RAM model; bit 8 marks a written location.
  logic [8:0] mem [0:255];
  logic       mem_clr = 1'b0;
  int         wr_count = 0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 9'h0;
    end else if (bus.buf_we) begin
      mem[bus.buf_addr[7:0]] <= {1'b1, bus.buf_wdata};
      wr_count <= wr_count + 1;
    end
  end

  byte unsigned fr[$];
  byte unsigned fr_keep[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [47:0] dest, input int npay, input bit seq);
    fr = {};
    for (int j = 0; j < 6; j++) fr.push_back(dest[47-8*j -: 8]);
    for (int j = 0; j < 6; j++) fr.push_back(8'($urandom));
    fr.push_back(8'h08);
    fr.push_back(8'h00);
    for (int k = 0; k < npay; k++) fr.push_back(seq ? 8'(k + 1) : 8'($urandom));
  endtask

  // Model: SFD byte always written; dest bytes must keep matching the local
  // address or all-ones, else writing stops before the failing byte.
  task automatic predict(input bit odd, output int nwr, output bit ok);
    bit m_ok, b_ok;
    m_ok = 1'b1;
    b_ok = 1'b1;
    nwr  = 1;
    ok   = 1'b0;
    for (int j = 0; j < fr.size(); j++) begin
      if (j < 6) begin
        m_ok = m_ok && (fr[j] == mac_addr[47-8*j -: 8]);
        b_ok = b_ok && (fr[j] == 8'hFF);
        if (!m_ok && !b_ok) return;
      end
      nwr++;
    end
    ok = !odd && (fr.size() == int'(rx_nbytes) + 14);
  endtask

  // Driven at a negedge; returns at the next negedge.
  task automatic nib(input logic [3:0] n);
    rx_dv   = 1'b1;
    rx_data = n;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[3:0]);
    nib(b[7:4]);
  endtask

  task automatic preamble(input int n55);
    repeat (n55) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic idle(input int n);
    rx_dv   = 1'b0;
    rx_data = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit odd);
    preamble(15);
    foreach (fr[i]) send_byte(fr[i]);
    if (odd) nib(4'h3);
    idle(4);
  endtask

  task automatic clr(output int base);
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    base = wr_count;
  endtask

  task automatic ack();
    rcv_ack = 1'b1;
    @(negedge clk);
    rcv_ack = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int nwr, input bit ok, input int base);
    int bad;
    logic [8:0] e;
    bad = 0;
    chk({tag, ":writes"}, 64'(wr_count - base), 64'(nwr));
    for (int a = 0; a < 256; a++) begin
      if (a == 0) e = {1'b1, 8'hD5};
      else if (a < nwr) e = {1'b1, fr[a-1]};
      else e = 9'h0;
      if (mem[a] !== e) bad++;
    end
    chk({tag, ":content"}, 64'(bad), 64'(0));
    chk({tag, ":ready"}, 64'(rx_ready), 64'(ok));
    chk({tag, ":err"}, 64'(rx_err), 64'(!ok));
  endtask

  initial begin
    int  base, base2, nwr, mode, npay;
    bit  ok, odd;

    rst_n     = 1'b0;
    rx_dv     = 1'b0;
    rx_data   = 4'h0;
    rcv_ack   = 1'b0;
    mac_addr  = 48'h02_11_22_33_44_55;
    rx_nbytes = AW'(64);

    #1;
    chk("rst:addr", 64'(bus.buf_addr), 64'(0));
    chk("rst:wdata", 64'(bus.buf_wdata), 64'(0));
    chk("rst:we", 64'(bus.buf_we), 64'(0));
    chk("rst:ready", 64'(rx_ready), 64'(0));
    chk("rst:err", 64'(rx_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: good frame, sequential payload; also SFD and first-byte latency.
    clr(base);
    build(mac_addr, 64, 1'b1);
    preamble(15);
    chk("t1:sfd_we", 64'(bus.buf_we), 64'(1));
    chk("t1:sfd_addr", 64'(bus.buf_addr), 64'(0));
    chk("t1:sfd_data", 64'(bus.buf_wdata), 64'hD5);
    send_byte(fr[0]);
    chk("t1:b1_we", 64'(bus.buf_we), 64'(1));
    chk("t1:b1_addr", 64'(bus.buf_addr), 64'(1));
    chk("t1:b1_data", 64'(bus.buf_wdata), 64'(fr[0]));
    for (int i = 1; i < fr.size(); i++) send_byte(fr[i]);
    idle(4);
    check_frame("t1", 79, 1'b1, base);
    chk("t1:pay0", 64'(mem[15]), {55'h0, 1'b1, 8'h01});
    chk("t1:pay63", 64'(mem[78]), {55'h0, 1'b1, 8'h40});

    // Test 6: release, then the same frame is re-received identically.
    ack();
    chk("t6:ready_clr", 64'(rx_ready), 64'(0));
    chk("t6:addr_clr", 64'(bus.buf_addr), 64'(0));
    clr(base);
    send_frame(1'b0);
    check_frame("t6", 79, 1'b1, base);
    ack();

    // Test 2: third dest byte corrupted, then a good frame without an ack.
    clr(base);
    build(mac_addr, 64, 1'b0);
    fr[2] = fr[2] ^ 8'h10;
    send_frame(1'b0);
    check_frame("t2", 3, 1'b0, base);
    clr(base);
    build(mac_addr, 64, 1'b0);
    send_frame(1'b0);
    check_frame("t2:next", 79, 1'b1, base);
    ack();

    // Test 3: broadcast destination.
    clr(base);
    build(48'hFFFF_FFFF_FFFF, 64, 1'b0);
    send_frame(1'b0);
    check_frame("t3", 79, 1'b1, base);
    ack();

    // Test 4: short frame dropped; ack clears err; frame during DONE ignored.
    clr(base);
    build(mac_addr, 10, 1'b0);
    send_frame(1'b0);
    check_frame("t4", 25, 1'b0, base);
    ack();
    chk("t4:ack_err", 64'(rx_err), 64'(0));
    clr(base);
    build(mac_addr, 64, 1'b0);
    send_frame(1'b0);
    fr_keep = fr;
    base2 = wr_count;
    build(mac_addr, 64, 1'b0);
    send_frame(1'b0);
    chk("t4:done_no_we", 64'(wr_count - base2), 64'(0));
    fr = fr_keep;
    check_frame("t4:held", 79, 1'b1, base);
    ack();

    // Test 5: reset mid-payload with rx_dv held high.
    clr(base);
    build(mac_addr, 64, 1'b0);
    preamble(15);
    for (int i = 0; i < 20; i++) send_byte(fr[i]);
    rst_n = 1'b0;
    #1;
    chk("t5:addr", 64'(bus.buf_addr), 64'(0));
    chk("t5:wdata", 64'(bus.buf_wdata), 64'(0));
    chk("t5:we", 64'(bus.buf_we), 64'(0));
    chk("t5:ready", 64'(rx_ready), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    base2 = wr_count;
    preamble(4);
    for (int i = 0; i < 30; i++) send_byte(fr[i]);
    idle(4);
    chk("t5:no_writes", 64'(wr_count - base2), 64'(0));
    chk("t5:err", 64'(rx_err), 64'(0));
    clr(base);
    build(mac_addr, 64, 1'b0);
    send_frame(1'b0);
    check_frame("t5:resync", 79, 1'b1, base);
    ack();

    // Randomized frames against the model.
    for (int it = 0; it < 10; it++) begin
      mac_addr = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
      mode = $urandom_range(0, 3);
      npay = $urandom_range(1, 40);
      odd  = 1'b0;
      rx_nbytes = AW'(npay);
      if (mode == 1) build(48'hFFFF_FFFF_FFFF, npay, 1'b0);
      else build(mac_addr, npay, 1'b0);
      if (mode == 2) begin
        int p;
        p = $urandom_range(0, 5);
        fr[p] = fr[p] ^ 8'(1 << $urandom_range(0, 7));
      end
      if (mode == 3) begin
        if ($urandom_range(0, 1) == 1) odd = 1'b1;
        else rx_nbytes = AW'(npay + $urandom_range(1, 3));
      end
      predict(odd, nwr, ok);
      clr(base);
      send_frame(odd);
      check_frame("rnd", nwr, ok, base);
      ack();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iob_eth_rx.md
IOB_ETH_RX -- requirements
Module: iob_eth_rx

Interface
REQ-001 SHALL have parameter BUF_ADDR_W, default 11, byte-address width of the receive buffer write port.
REQ-002 SHALL have parameter PREAMBLE_MIN, default 2, minimum count of 0x5 nibbles required before the SFD nibble 0xD.
REQ-003 SHALL have port clk, input, 1, the single clock: the MII RX_CLK domain, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous assert, active-low.
REQ-005 SHALL have port rx_dv, input, 1, MII receive data valid.
REQ-006 SHALL have port rx_data, input, 4, MII receive nibble.
REQ-007 SHALL have port mac_addr, input, 48, local MAC address; bits [47:40] are the first byte on the wire.
REQ-008 SHALL have port rx_nbytes, input, BUF_ADDR_W, expected payload byte count after the 14-byte header.
REQ-009 SHALL have port rcv_ack, input, 1, one-cycle pulse from the CPU side that releases the buffer and re-arms the receiver.
REQ-010 SHALL have port buf_addr, output, BUF_ADDR_W, buffer write address.
REQ-011 SHALL have port buf_wdata, output, 8, buffer write byte.
REQ-012 SHALL have port buf_we, output, 1, buffer write strobe, one cycle per byte.
REQ-013 SHALL have port rx_ready, output, 1, frame accepted and buffer valid (STATUS bit 1).
REQ-014 SHALL have port rx_err, output, 1, sticky flag: last frame dropped.

Function
REQ-015 SHALL implement FSM states IDLE, PREAMBLE, DATA, DONE and DROP.
REQ-016 SHALL leave IDLE for PREAMBLE on rx_dv=1 with rx_data=0x5; any other nibble while rx_dv=1 SHALL go to DROP.
REQ-017 In PREAMBLE, SHALL count 0x5 nibbles in a 4-bit counter that saturates at 15.
REQ-018 In PREAMBLE, rx_data=0xD with count>=PREAMBLE_MIN SHALL go to DATA; 0xD with count<PREAMBLE_MIN, any other nibble, or rx_dv=0 SHALL go to DROP.
REQ-019 On entry to DATA, SHALL write byte 0xD5 at buf_addr 0; the received frame then follows from address 1.
REQ-020 SHALL assemble bytes low nibble first: the first nibble is bits [3:0], the second is [7:4].
REQ-021 SHALL pulse buf_we for one cycle on the cycle after each second nibble, and increment buf_addr after each write.
REQ-022 Latency from the high-nibble sample to buf_we SHALL be 1 clk.
REQ-023 SHALL compare bytes 1..6 (destination MAC) against mac_addr, and also accept FF:FF:FF:FF:FF:FF; on a mismatch the FSM SHALL go to DROP at the failing byte.
REQ-024 If buf_addr reaches 2^BUF_ADDR_W-1 while rx_dv=1, SHALL stop writing (no wrap-around) and go to DROP.
REQ-025 When rx_dv falls in DATA: if an odd nibble count, or bytes written != rx_nbytes+15, SHALL go to DROP; otherwise SHALL go to DONE.
REQ-026 In DONE, rx_ready=1, buf_we SHALL stay 0, and all rx_dv activity SHALL be ignored.
REQ-027 rcv_ack in DONE SHALL clear rx_ready, reset buf_addr to 0 and go to IDLE in 1 clk.
REQ-028 DROP SHALL set rx_err, keep rx_ready=0, and wait for rx_dv=0 before returning to IDLE.
REQ-029 rcv_ack in any state other than DONE SHALL have no effect except clearing rx_err.
REQ-030 rx_err SHALL clear on rcv_ack or on the next frame that reaches DONE.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, buf_addr=0, buf_wdata=0, buf_we=0, rx_ready=0, rx_err=0, and clear the nibble and preamble counters.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release the FSM SHALL re-sync on the next preamble only and ignore the remainder of the current frame by requiring rx_dv=0 first.

Structure
REQ-033 SHALL take the SFD value, broadcast address, header length 14 and FSM state encodings from the shared definitions header iob_eth_defs.vh.
REQ-034 SHALL contain no sub-module; the buffer RAM is external and instantiated in the parent iob_eth.
REQ-035 The CPU-side clock-domain crossing of rx_ready and rcv_ack SHALL be the parent's responsibility.

Verification
REQ-036 Test 1: 15x 0x55, D5, dest=mac_addr, src, 0x0800, payload 1..N with rx_nbytes=N=64 -> 79 writes, addr0=D5, addr15+k=k+1, rx_ready=1, rx_err=0.
REQ-037 Test 2: same frame with one dest byte flipped -> writes stop at the failing byte, rx_err=1, rx_ready=0; the next good frame reaches DONE.
REQ-038 Test 3: broadcast destination FF..FF -> accepted, rx_ready=1.
REQ-039 Test 4: rx_dv drops after 10 payload bytes with rx_nbytes=64 -> DROP, rx_err=1; a second frame while in DONE -> no buf_we, buffer unchanged.
REQ-040 Test 5: rst_n pulsed low mid-payload -> outputs 0 immediately; with rx_dv still high, no writes until rx_dv=0 and a new preamble arrives.
REQ-041 Test 6: rcv_ack in DONE -> rx_ready=0 next cycle and buf_addr=0; a loopback frame via MII (as in the iob_eth bench) is then re-received identically.
